// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master engines.
// Bus drive decode lives here so a read engine can reuse it.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    STOP
  } state_t;

  localparam int   QUARTERS = 4;
  localparam logic RW_WRITE = 1'b0;

  typedef logic [1:0] quarter_t;

  localparam quarter_t Q_LAST   = quarter_t'(QUARTERS - 1);
  localparam quarter_t Q_SAMPLE = quarter_t'(QUARTERS - 2);

  typedef struct packed {
    logic scl_low;
    logic sda_low;
  } bus_drv_t;

  function automatic bus_drv_t bus_drive(
    input state_t   st,
    input quarter_t q,
    input logic     b
  );
    bus_drv_t d;
    d = '0;
    unique case (st)
      START: d.sda_low = q[1];
      ADDR, DATA: begin
        d.scl_low = ~q[1];
        d.sda_low = ~b;
      end
      ADDR_ACK, DATA_ACK: d.scl_low = ~q[1];
      STOP: begin
        d.scl_low = (q == 2'd0);
        d.sda_low = ~q[1];
      end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/i2c_tick_detect.sv
// Turns the divided clock into a one-cycle phase strobe
// in the system clock domain; the divided clock never clocks logic.
module i2c_tick_detect #(
  parameter bit TICK_RISING = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_div_clk,
  output logic o_tick
);

  logic r_div_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_q <= 1'b0;
    end else begin
      r_div_q <= i_div_clk;
    end
  end

  assign o_tick = TICK_RISING ? (i_div_clk & ~r_div_q)
                              : (~i_div_clk & r_div_q);

endmodule

// File: rtl/i2c_write_engine.sv
// Single-byte I2C master write: START, addr+W, ACK, data, ACK, STOP.
// Every bus bit is four ticks; SCL/SDA are open-drain pull enables.
module i2c_write_engine
  import i2c_pkg::*;
#(
  parameter bit TICK_RISING    = 1'b1,
  parameter bit CHECK_DATA_ACK = 1'b1
) (
  input  logic       clock_in,
  input  logic       reset_n,
  input  logic       div_clk_in,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       sda_in,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl_low,
  output logic       sda_low
);

  state_t     r_state;
  state_t     w_state;
  quarter_t   r_q;
  quarter_t   w_q;
  logic [2:0] r_bit;
  logic [2:0] w_bit;
  logic [7:0] r_sh;
  logic [7:0] w_sh;
  logic [7:0] r_wdata;
  logic [7:0] w_wdata;
  logic       r_busy;
  logic       w_busy;
  logic       r_done;
  logic       w_done;
  logic       r_err;
  logic       w_err;
  logic       w_tick;
  logic       w_wrap;
  logic       w_sample;
  bus_drv_t   w_drv;

  i2c_tick_detect #(
    .TICK_RISING(TICK_RISING)
  ) u_tick (
    .i_clk    (clock_in),
    .i_rst_n  (reset_n),
    .i_div_clk(div_clk_in),
    .o_tick   (w_tick)
  );

  assign w_wrap   = w_tick && (r_q == Q_LAST);
  assign w_sample = w_tick && (r_q == Q_SAMPLE);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_q     <= w_q;
      r_bit   <= w_bit;
      r_sh    <= w_sh;
      r_wdata <= w_wdata;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end

  always_comb begin
    w_state = r_state;
    w_q     = r_q;
    w_bit   = r_bit;
    w_sh    = r_sh;
    w_wdata = r_wdata;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_err   = r_err;

    if (r_state != IDLE && w_tick) begin
      w_q = r_q + 2'd1;
    end

    unique case (r_state)
      IDLE: begin
        // the done cycle still counts as busy for a new request
        if (start && !r_done) begin
          w_state = START;
          w_q     = '0;
          w_bit   = 3'd7;
          w_sh    = {addr, RW_WRITE};
          w_wdata = wdata;
          w_busy  = 1'b1;
          w_err   = 1'b0;
        end
      end
      START: begin
        if (w_wrap) begin
          w_state = ADDR;
          w_bit   = 3'd7;
        end
      end
      ADDR, DATA: begin
        if (w_wrap) begin
          if (r_bit == 3'd0) begin
            w_state = (r_state == ADDR) ? ADDR_ACK : DATA_ACK;
          end else begin
            w_bit = r_bit - 3'd1;
            w_sh  = {r_sh[6:0], 1'b0};
          end
        end
      end
      ADDR_ACK: begin
        if (w_sample && sda_in) begin
          w_err = 1'b1;
        end
        // r_err here can only come from this address slot
        if (w_wrap) begin
          if (r_err) begin
            w_state = STOP;
          end else begin
            w_state = DATA;
            w_sh    = r_wdata;
            w_bit   = 3'd7;
          end
        end
      end
      DATA_ACK: begin
        if (w_sample && sda_in && CHECK_DATA_ACK) begin
          w_err = 1'b1;
        end
        if (w_wrap) begin
          w_state = STOP;
        end
      end
      STOP: begin
        if (w_wrap) begin
          w_state = IDLE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign w_drv   = bus_drive(r_state, r_q, r_sh[7]);
  assign scl_low = w_drv.scl_low;
  assign sda_low = w_drv.sda_low;
  assign busy    = r_busy;
  assign done    = r_done;
  assign ack_err = r_err;

endmodule

// File: tb/tb_i2c_write_engine.sv
// Bench for i2c_write_engine: bus-level decode, responder,
// table vectors, corner sequences and randomized transactions.
module tb_i2c_write_engine;

  logic       clock_in = 1'b0;
  logic       reset_n = 1'b0;
  logic       div_clk_in = 1'b0;
  logic       start = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       sda_in = 1'b1;
  logic busy, done, ack_err, scl_low, sda_low;
  logic busy0, done0, ack_err0, scl_low0, sda_low0;

  i2c_write_engine #(.TICK_RISING(1'b1), .CHECK_DATA_ACK(1'b1)) u_dut (
    .clock_in(clock_in), .reset_n(reset_n), .div_clk_in(div_clk_in),
    .start(start), .addr(addr), .wdata(wdata), .sda_in(sda_in),
    .busy(busy), .done(done), .ack_err(ack_err),
    .scl_low(scl_low), .sda_low(sda_low)
  );

  i2c_write_engine #(.TICK_RISING(1'b1), .CHECK_DATA_ACK(1'b0)) u_dut0 (
    .clock_in(clock_in), .reset_n(reset_n), .div_clk_in(div_clk_in),
    .start(start), .addr(addr), .wdata(wdata), .sda_in(sda_in),
    .busy(busy0), .done(done0), .ack_err(ack_err0),
    .scl_low(scl_low0), .sda_low(sda_low0)
  );

  always #5 clock_in = ~clock_in;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // clk_div stand-in: period of per system clocks
  int per = 4;
  int dcnt = 0;
  always @(negedge clock_in) begin
    dcnt = (dcnt + 1) % per;
    div_clk_in = (dcnt < per / 2);
  end

  // tick counting from acceptance to done
  logic dq = 1'b0;
  int   tick_cnt = 0;
  bit   cnt_en = 0;
  bit   just_done = 0;
  always @(posedge clock_in) begin
    logic tk;
    if (!reset_n) begin
      dq = 1'b0;
      cnt_en = 0;
      just_done = 0;
    end else begin
      tk = div_clk_in & ~dq;
      dq = div_clk_in;
      if (cnt_en) tick_cnt += int'(tk);
      else if (start && !just_done) begin
        cnt_en = 1;
        tick_cnt = 0;
      end
      just_done = 0;
    end
  end

  // bus decoder, protocol monitor and responder
  logic        ps = 1'b0, pd = 1'b0;
  int          nstart, nstop, nviol, ndone, ndone0, nbits, nfall, done_ticks;
  logic [31:0] bits;
  bit          bus_act, done0_same, ar_r, dr_r;
  always @(negedge clock_in) begin
    if (done === 1'b1) begin
      ndone++;
      done_ticks = tick_cnt;
      done0_same = done0;
      cnt_en = 0;
      just_done = 1;
    end
    if (done0 === 1'b1) ndone0++;
    if (sda_low !== pd) begin
      if (!scl_low && !ps) begin
        if (sda_low) begin
          nstart++;
          if (bus_act) nviol++;
          bus_act = 1;
          nfall = 0;
        end else begin
          nstop++;
          if (!bus_act) nviol++;
          bus_act = 0;
          if (nbits > 0) begin
            nbits--;
            bits = bits >> 1;
          end
        end
      end else if (!scl_low && ps) begin
        nviol++;
      end
    end
    if (ps && !scl_low) begin
      bits = {bits[30:0], ~sda_low};
      nbits++;
    end
    if (!ps && scl_low) nfall++;
    sda_in = (nfall == 9) ? ar_r : (nfall == 18) ? dr_r : 1'b1;
    ps = scl_low;
    pd = sda_low;
  end

  task automatic step();
    @(negedge clock_in);
    #1;
  endtask

  task automatic clear_mon(input bit ar, input bit dr);
    nstart = 0; nstop = 0; nviol = 0; ndone = 0; ndone0 = 0;
    nbits = 0; nfall = 0; bits = '0; bus_act = 0;
    done_ticks = -1; done0_same = 0;
    ar_r = ar; dr_r = dr;
  endtask

  // reference: what the bus and flags must show for one write
  function automatic void model(
    input logic [6:0] a, input logic [7:0] d, input bit ar, input bit dr,
    input bit chkd, output int ticks, output bit err,
    output int nb, output logic [31:0] bv
  );
    ticks = 4 + 36 + (ar ? 0 : 36) + 4;
    err = ar | (chkd & dr);
    nb = ar ? 9 : 18;
    bv = ar ? 32'({a, 1'b0, 1'b1}) : 32'({a, 1'b0, 1'b1, d, 1'b1});
  endfunction

  task automatic run_tx(
    input string tag, input logic [6:0] a, input logic [7:0] d,
    input bit ar, input bit dr, input int extra_at, input bit start_on_done
  );
    int t_exp, nb_exp;
    bit e1, e0, ex_sent, timed_out;
    logic [31:0] bv_exp, bv_dummy;
    int t_dummy, nb_dummy;
    model(a, d, ar, dr, 1'b1, t_exp, e1, nb_exp, bv_exp);
    model(a, d, ar, dr, 1'b0, t_dummy, e0, nb_dummy, bv_dummy);
    clear_mon(ar, dr);
    repeat ($urandom_range(0, per)) step();
    addr = a; wdata = d; start = 1'b1;
    step();
    start = 1'b0;
    addr = ~a; wdata = ~d;
    chk({tag, "_busy_on_accept"}, busy, 1);
    chk({tag, "_err_cleared"}, {ack_err, ack_err0}, 0);
    ex_sent = 0;
    timed_out = 1;
    for (int i = 0; i < 90 * per + 100; i++) begin
      step();
      if (extra_at >= 0 && !ex_sent && tick_cnt >= extra_at) begin
        addr = 7'h11; wdata = 8'h3C; start = 1'b1;
        step();
        start = 1'b0;
        ex_sent = 1;
      end
      if (ndone > 0) begin
        timed_out = 0;
        break;
      end
    end
    chk({tag, "_timeout"}, timed_out, 0);
    chk({tag, "_ticks"}, done_ticks, t_exp);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_ack_err"}, ack_err, e1);
    chk({tag, "_ack_err_nochk"}, ack_err0, e0);
    chk({tag, "_done_nochk_same"}, done0_same, 1);
    chk({tag, "_nbits"}, nbits, nb_exp);
    chk({tag, "_bits"}, bits, bv_exp);
    chk({tag, "_start_cond"}, nstart, 1);
    chk({tag, "_stop_cond"}, nstop, 1);
    chk({tag, "_protocol"}, nviol, 0);
    if (start_on_done) begin
      start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, "_start_on_done_ignored"}, {busy, busy0}, 0);
    end
    repeat (3) step();
    chk({tag, "_one_done"}, {ndone[15:0], ndone0[15:0]}, {16'd1, 16'd1});
    chk({tag, "_sticky_err"}, ack_err, e1);
    chk({tag, "_idle_bus"}, {busy, scl_low, sda_low}, 0);
  endtask

  typedef struct {
    logic [6:0] a;
    logic [7:0] d;
    bit         ar;
    bit         dr;
    int         ticks;
    bit         err1;
    bit         err0;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{7'h50, 8'hA5, 1'b0, 1'b0, 80, 1'b0, 1'b0};
    tbl[1] = '{7'h3C, 8'h81, 1'b1, 1'b1, 44, 1'b1, 1'b1};
    tbl[2] = '{7'h2A, 8'h5A, 1'b0, 1'b1, 80, 1'b1, 1'b0};
    tbl[3] = '{7'h7F, 8'h00, 1'b0, 1'b0, 80, 1'b0, 1'b0};
    tbl[4] = '{7'h00, 8'hFF, 1'b1, 1'b0, 44, 1'b1, 1'b1};

    repeat (3) step();
    chk("reset_outputs", {busy, done, ack_err, scl_low, sda_low}, 0);
    chk("reset_outputs_nochk",
        {busy0, done0, ack_err0, scl_low0, sda_low0}, 0);
    reset_n = 1'b1;
    repeat (3) step();

    for (int i = 0; i < 5; i++) begin
      clear_mon(tbl[i].ar, tbl[i].dr);
      run_tx($sformatf("tbl%0d", i), tbl[i].a, tbl[i].d,
             tbl[i].ar, tbl[i].dr, -1, 1'b0);
      chk($sformatf("tbl%0d_tab_ticks", i), done_ticks, tbl[i].ticks);
      chk($sformatf("tbl%0d_tab_err", i), {ack_err, ack_err0},
          {tbl[i].err1, tbl[i].err0});
    end

    run_tx("busy_start", 7'h50, 8'hA5, 1'b0, 1'b0, 20, 1'b0);
    run_tx("done_start", 7'h21, 8'h96, 1'b0, 1'b0, -1, 1'b1);

    // reset while DATA bit 3 is on the bus
    clear_mon(1'b0, 1'b0);
    addr = 7'h50; wdata = 8'hA5; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 2000 && tick_cnt < 57; i++) step();
    chk("mid_pre_reset_bus", {busy, scl_low, sda_low}, 3'b111);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_reset_async", {busy, scl_low, sda_low}, 0);
    chk("mid_reset_async_nochk", {busy0, scl_low0, sda_low0}, 0);
    repeat (2) step();
    reset_n = 1'b1;
    repeat (2) step();
    run_tx("after_reset", 7'h50, 8'hA5, 1'b0, 1'b0, -1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      per = 2 + int'($urandom_range(0, 4));
      repeat (2) step();
      run_tx($sformatf("rnd%0d", i), 7'($urandom), 8'($urandom),
             ($urandom_range(0, 3) == 0), 1'($urandom), -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
